// File: rtl/rsa_word_loader_if.sv
// Handshake bundle between a word-serial host and rsa_word_loader.
// The master drives words in and takes frames out; the slave is the loader.
interface rsa_word_loader_if #(
    parameter int WORD_WIDTH  = 32,
    parameter int FRAME_WIDTH = 768
);
    logic                   i_valid;
    logic                   i_ready;
    logic [WORD_WIDTH-1:0]  i_word;
    logic                   o_valid;
    logic                   o_ready;
    logic [FRAME_WIDTH-1:0] o_out;
    logic                   o_err;

    modport master (
        output i_valid, i_word, o_ready,
        input  i_ready, o_valid, o_out, o_err
    );

    modport slave (
        input  i_valid, i_word, o_ready,
        output i_ready, o_valid, o_out, o_err
    );
endinterface

// File: rtl/rsa_word_loader.sv
// Word-serial loader that assembles {msg, key, modulus} into one RSAModIn frame.
// Optional feature: RSA_LOADER_MOD_ODD_CHECK_EN rejects frames whose modulus is even.
package RSA_pkg;
    localparam int MOD_WIDTH = 256;

    typedef struct packed {
        logic [MOD_WIDTH-1:0] msg;
        logic [MOD_WIDTH-1:0] key;
        logic [MOD_WIDTH-1:0] modulus;
    } RSAModIn;
endpackage

module rsa_word_loader
    import RSA_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    rsa_word_loader_if.slave   io_bus
);
    localparam int NW    = MOD_WIDTH / WORD_WIDTH;
    localparam int NT    = 3 * NW;
    localparam int CNT_W = $clog2(NT);

    if (MOD_WIDTH % WORD_WIDTH != 0) begin : g_badWidth
        $error("rsa_word_loader: MOD_WIDTH must be a multiple of WORD_WIDTH");
    end

    typedef enum logic {COLLECT, FULL} state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [CNT_W-1:0]      r_cnt;
    logic [WORD_WIDTH-1:0] r_buf [NT];
    logic                  w_accept;
    logic                  w_last;
    logic                  w_reject;
    logic                  w_ready;
    logic                  w_valid;
    RSAModIn               w_frame;

    assign w_accept = (r_state == COLLECT) && io_bus.i_valid;
    assign w_last   = (r_cnt == CNT_W'(NT - 1));

`ifdef RSA_LOADER_MOD_ODD_CHECK_EN
    logic w_modLsb;
    logic r_err;

    // With a single word per field the modulus LSW is the last word itself.
    assign w_modLsb = (r_cnt == CNT_W'(2 * NW)) ? io_bus.i_word[0] : r_buf[2*NW][0];
    assign w_reject = w_last && !w_modLsb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && w_reject;
        end
    end

    assign io_bus.o_err = r_err;
`else
    assign w_reject     = 1'b0;
    assign io_bus.o_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_ready     = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            COLLECT: begin
                w_ready = 1'b1;
                if (w_accept && w_last && !w_reject) begin
                    w_nextState = FULL;
                end
            end
            FULL: begin
                w_valid = 1'b1;
                if (io_bus.o_ready) begin
                    w_nextState = COLLECT;
                end
            end
            default: w_nextState = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            for (int s = 0; s < NT; s++) begin
                r_buf[s] <= '0;
            end
        end else if (w_accept) begin
            r_buf[r_cnt] <= io_bus.i_word;
            r_cnt        <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Slot order is msg, key, modulus; each field is filled least-significant word first.
    for (genvar k = 0; k < NW; k++) begin : g_pack
        assign w_frame.msg[k*WORD_WIDTH +: WORD_WIDTH]     = r_buf[k];
        assign w_frame.key[k*WORD_WIDTH +: WORD_WIDTH]     = r_buf[NW + k];
        assign w_frame.modulus[k*WORD_WIDTH +: WORD_WIDTH] = r_buf[2*NW + k];
    end

    assign io_bus.i_ready = w_ready;
    assign io_bus.o_valid = w_valid;
    assign io_bus.o_out   = w_frame;
endmodule

// File: tb/tb_rsa_word_loader.sv
// Directed scoreboard bench for rsa_word_loader (MOD_WIDTH=256, WORD_WIDTH=32).
// Honours RSA_LOADER_MOD_ODD_CHECK_EN for the even-modulus expectations.
module tb_rsa_word_loader;
    import RSA_pkg::*;

    localparam int WW = 32;
    localparam int NW = MOD_WIDTH / WW;
    localparam int NT = 3 * NW;
    localparam int FW = $bits(RSAModIn);

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    logic [FW-1:0] expQ [$];
    int            hsQ [$];
    logic [WW-1:0] baseWords [NT];
    logic [WW-1:0] evenWords [NT];
    logic [WW-1:0] secondWords [NT];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    rsa_word_loader_if #(.WORD_WIDTH(WW), .FRAME_WIDTH(FW)) bus ();

    rsa_word_loader #(.WORD_WIDTH(WW)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkScalar(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference packing built independently from the word-order rules.
    function automatic logic [FW-1:0] buildFrame(input logic [WW-1:0] words [NT]);
        logic [FW-1:0] f;
        f = '0;
        for (int s = 0; s < NT; s++) begin
            f[(2 - s / NW) * MOD_WIDTH + (s % NW) * WW +: WW] = words[s];
        end
        return f;
    endfunction

    // Scoreboard pop on every frame handshake.
    always @(negedge clk) begin
        if (rst && bus.o_valid && bus.o_ready) begin
            hsQ.push_back(cyc);
            if (expQ.size() == 0) begin
                checkScalar("unexpectedFrame", 1, 0);
            end else begin
                checkOutput("frame", bus.o_out, expQ.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Called at posedge+1; returns at posedge+1 after the word was accepted.
    task automatic applyStimulus(input logic [WW-1:0] w);
        int  guard;
        logic rdy;
        guard = 0;
        bus.i_valid = 1'b1;
        bus.i_word  = w;
        forever begin
            rdy = bus.i_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            guard++;
            if (guard > 200) begin
                checkScalar("acceptTimeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic idleCycle();
        bus.i_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input logic [WW-1:0] words [NT], input bit gaps,
                             input bit holdValid, input bit expectFrame);
        for (int s = 0; s < NT; s++) begin
            if (gaps && s > 0 && $urandom_range(1) == 0) idleCycle();
            applyStimulus(words[s]);
        end
        if (!holdValid) bus.i_valid = 1'b0;
        if (expectFrame) expQ.push_back(buildFrame(words));
    endtask

    initial begin
        for (int s = 0; s < NT; s++) begin
            baseWords[s]   = WW'(s + 1);
            evenWords[s]   = WW'(s + 1);
            secondWords[s] = WW'(32'h100 + s * 3);
        end
        evenWords[2*NW] = 32'h10;

        bus.i_valid = 1'b0;
        bus.i_word  = '0;
        bus.o_ready = 1'b0;

        #2;
        checkScalar("resetIReady", 32'(bus.i_ready), 1);
        checkScalar("resetOValid", 32'(bus.o_valid), 0);
        checkScalar("resetOErr", 32'(bus.o_err), 0);
        checkOutput("resetOOut", bus.o_out, '0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] scenario 1: back-to-back frame");
        bus.o_ready = 1'b1;
        sendFrame(baseWords, 1'b0, 1'b0, 1'b1);
        checkScalar("s1ValidAfterLast", 32'(bus.o_valid), 1);
        checkScalar("s1ReadyLowFull", 32'(bus.i_ready), 0);
        @(posedge clk);
        #1;
        checkScalar("s1ValidOneCycle", 32'(bus.o_valid), 0);
        checkScalar("s1ReadyBack", 32'(bus.i_ready), 1);

        $display("[TB] scenario 2: downstream stall");
        bus.o_ready = 1'b0;
        sendFrame(baseWords, 1'b0, 1'b0, 1'b1);
        bus.i_valid = 1'b1;
        bus.i_word  = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkScalar("s2ValidHeld", 32'(bus.o_valid), 1);
            checkScalar("s2ReadyLow", 32'(bus.i_ready), 0);
            checkOutput("s2OutStable", bus.o_out, expQ[0]);
        end
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b1;
        @(posedge clk);
        #1;
        checkScalar("s2ValidDrop", 32'(bus.o_valid), 0);
        checkScalar("s2ReadyBack", 32'(bus.i_ready), 1);

        $display("[TB] scenario 3: gapped input");
        sendFrame(baseWords, 1'b1, 1'b0, 1'b1);
        idleCycle();

        $display("[TB] scenario 4: reset mid-frame");
        for (int s = 0; s < 5; s++) applyStimulus(baseWords[s]);
        bus.i_valid = 1'b0;
        rst = 1'b0;
        #1;
        checkScalar("s4ReadyInReset", 32'(bus.i_ready), 1);
        checkScalar("s4ValidInReset", 32'(bus.o_valid), 0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        sendFrame(baseWords, 1'b0, 1'b0, 1'b1);
        idleCycle();
        bus.o_ready = 1'b0;
        sendFrame(baseWords, 1'b0, 1'b0, 1'b1);
        checkScalar("s4ValidBeforeReset", 32'(bus.o_valid), 1);
        rst = 1'b0;
        #1;
        checkScalar("s4ValidDropAsync", 32'(bus.o_valid), 0);
        void'(expQ.pop_front());
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus.o_ready = 1'b1;

        $display("[TB] scenario 5: even modulus");
`ifdef RSA_LOADER_MOD_ODD_CHECK_EN
        sendFrame(evenWords, 1'b0, 1'b0, 1'b0);
        checkScalar("s5NoValid", 32'(bus.o_valid), 0);
        checkScalar("s5ErrPulse", 32'(bus.o_err), 1);
        checkScalar("s5ReadyKept", 32'(bus.i_ready), 1);
        @(posedge clk);
        #1;
        checkScalar("s5ErrOneCycle", 32'(bus.o_err), 0);
        checkScalar("s5StillNoValid", 32'(bus.o_valid), 0);
        sendFrame(baseWords, 1'b0, 1'b0, 1'b1);
        checkScalar("s5NextFrameValid", 32'(bus.o_valid), 1);
`else
        sendFrame(evenWords, 1'b0, 1'b0, 1'b1);
        checkScalar("s5ValidEven", 32'(bus.o_valid), 1);
        checkScalar("s5ErrZero", 32'(bus.o_err), 0);
        checkScalar("s5ModLsw", int'(bus.o_out[WW-1:0]), 32'h10);
`endif
        idleCycle();
        checkScalar("s5ErrIdle", 32'(bus.o_err), 0);

        $display("[TB] scenario 6: two frames continuous");
        hsQ.delete();
        sendFrame(baseWords, 1'b0, 1'b1, 1'b1);
        sendFrame(secondWords, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkScalar("s6Handshakes", hsQ.size(), 2);
        if (hsQ.size() == 2) checkScalar("s6FramePeriod", hsQ[1] - hsQ[0], NT + 1);

        repeat (3) @(posedge clk);
        #1;
        checkScalar("scoreboardEmpty", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
